// File: rtl/reg_serial_tx.sv
// Parallel-to-serial transmitter for the serial register interface (OUT + Load strobe).
// Optional even-parity trailer bit enabled by defining REG_SERIAL_TX_PARITY_EN.
module reg_serial_tx #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [WIDTH-1:0] din,
  output logic             ready,
  output logic             OUT,
  output logic             Load,
  output logic             done,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned GAP_W = 4;

`ifdef REG_SERIAL_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR, GAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

  state_t             r_state;
  logic [WIDTH-1:0]   r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic [GAP_W-1:0]   r_gap;
  logic               r_out;
  logic               r_load;
  logic               r_done;
`ifdef REG_SERIAL_TX_PARITY_EN
  logic               r_par;
`endif

  logic               w_first_bit;
  logic               w_next_bit;
  logic [WIDTH-1:0]   w_shifted;

  // Bit selection depends only on transmit order; the shift register holds the not-yet-sent bits at the head.
  assign w_first_bit = MSB_FIRST ? din[WIDTH-1]       : din[0];
  assign w_next_bit  = MSB_FIRST ? r_shift[WIDTH-2]   : r_shift[1];
  assign w_shifted   = MSB_FIRST ? (r_shift << 1)     : (r_shift >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_gap   <= '0;
      r_out   <= 1'b0;
      r_load  <= 1'b0;
      r_done  <= 1'b0;
`ifdef REG_SERIAL_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (valid) begin
            r_shift <= din;
            r_cnt   <= CNT_W'(WIDTH - 1);
            r_out   <= w_first_bit;
            r_load  <= 1'b1;
`ifdef REG_SERIAL_TX_PARITY_EN
            r_par   <= ^din;
`endif
            r_state <= SHIFT;
          end
        end

        SHIFT: begin
          if (r_cnt != '0) begin
            r_shift <= w_shifted;
            r_out   <= w_next_bit;
            r_cnt   <= r_cnt - CNT_W'(1);
          end else begin
`ifdef REG_SERIAL_TX_PARITY_EN
            r_shift <= w_shifted;
            r_out   <= r_par;
            r_state <= PAR;
`else
            r_shift <= w_shifted;
            r_out   <= 1'b0;
            r_load  <= 1'b0;
            r_done  <= 1'b1;
            r_gap   <= GAP_W'(GAP_CYCLES);
            r_state <= (GAP_CYCLES > 0) ? GAP : IDLE;
`endif
          end
        end

`ifdef REG_SERIAL_TX_PARITY_EN
        PAR: begin
          r_out   <= 1'b0;
          r_load  <= 1'b0;
          r_done  <= 1'b1;
          r_gap   <= GAP_W'(GAP_CYCLES);
          r_state <= (GAP_CYCLES > 0) ? GAP : IDLE;
        end
`endif

        // The done cycle plus GAP_CYCLES further cycles are held off before the next handshake.
        GAP: begin
          if (r_gap == '0) begin
            r_state <= IDLE;
          end else begin
            r_gap <= r_gap - GAP_W'(1);
          end
        end

        default: begin
          r_state <= IDLE;
          r_load  <= 1'b0;
          r_out   <= 1'b0;
        end
      endcase
    end
  end

  assign ready = (r_state == IDLE);
  assign busy  = (r_state != IDLE);
  assign OUT   = r_out;
  assign Load  = r_load;
  assign done  = r_done;

endmodule

// File: tb/tb_reg_serial_tx.sv
// Scoreboard bench for reg_serial_tx: two instances (MSB-first/no gap, LSB-first/gap 3),
// a receiver-style monitor reassembles each frame and checks it against queued words.
module tb_reg_serial_tx;

  localparam int unsigned W = 8;
`ifdef REG_SERIAL_TX_PARITY_EN
  localparam int unsigned NB = W + 1;
`else
  localparam int unsigned NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_a [2];
  logic [W-1:0] din_a   [2];
  logic         ready_a [2];
  logic         out_a   [2];
  logic         load_a  [2];
  logic         done_a  [2];
  logic         busy_a  [2];

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  always #5 clk = ~clk;

  reg_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1), .GAP_CYCLES(0)) u0 (
    .clk(clk), .rst_n(rst_n), .valid(valid_a[0]), .din(din_a[0]), .ready(ready_a[0]),
    .OUT(out_a[0]), .Load(load_a[0]), .done(done_a[0]), .busy(busy_a[0]));

  reg_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0), .GAP_CYCLES(3)) u1 (
    .clk(clk), .rst_n(rst_n), .valid(valid_a[1]), .din(din_a[1]), .ready(ready_a[1]),
    .OUT(out_a[1]), .Load(load_a[1]), .done(done_a[1]), .busy(busy_a[1]));

  function automatic bit msbf(int k);
    return (k == 0);
  endfunction

  function automatic int gap_of(int k);
    return (k == 0) ? 0 : 3;
  endfunction

  // Bits in transmission order: index 0 is the first bit seen on OUT.
  function automatic logic [31:0] exp_seq(int k, logic [W-1:0] w);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < int'(W); i++) s[i] = msbf(k) ? w[int'(W) - 1 - i] : w[i];
`ifdef REG_SERIAL_TX_PARITY_EN
    s[W] = ^w;
`endif
    return s;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Receiver-side monitor
  int          nb   [2];
  logic [31:0] seq  [2];
  bit          in_gap [2];
  int          gcnt [2];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        nb[k] = 0; seq[k] = '0; in_gap[k] = 0; gcnt[k] = 0;
      end else begin
        if (in_gap[k]) begin
          if (!ready_a[k]) gcnt[k]++;
          else begin
            chk($sformatf("gap_len%0d", k), gcnt[k], (gap_of(k) == 0) ? 0 : gap_of(k) + 1);
            in_gap[k] = 0;
          end
        end
        if (load_a[k]) begin
          chk($sformatf("busy_in_frame%0d", k), busy_a[k], 1);
          if (nb[k] < 32) seq[k][nb[k]] = out_a[k];
          nb[k]++;
        end
        if (done_a[k]) begin
          int sz;
          logic [W-1:0] w;
          chk($sformatf("done_out%0d", k), out_a[k], 0);
          chk($sformatf("done_load%0d", k), load_a[k], 0);
          sz = (k == 0) ? exp_q0.size() : exp_q1.size();
          chk($sformatf("frame_pending%0d", k), (sz != 0), 1);
          if (sz != 0) begin
            w = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("frame_len%0d", k), nb[k], NB);
            chk($sformatf("frame_bits%0d", k), seq[k], exp_seq(k, w));
          end
          nb[k] = 0; seq[k] = '0;
          gcnt[k] = ready_a[k] ? 0 : 1;
          in_gap[k] = 1;
          if (ready_a[k]) begin
            chk($sformatf("gap_len%0d", k), 0, (gap_of(k) == 0) ? 0 : gap_of(k) + 1);
            in_gap[k] = 0;
          end
        end
      end
    end
  end

  task automatic send(input int k, input logic [W-1:0] w, input bit keep);
    int t;
    t = 0;
    @(negedge clk);
    valid_a[k] = 1'b1;
    din_a[k]   = w;
    while (!ready_a[k] && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!ready_a[k]) begin
      chk($sformatf("handshake_timeout%0d", k), ready_a[k], 1);
      valid_a[k] = 1'b0;
      return;
    end
    @(posedge clk);
    if (k == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
    #1;
    chk($sformatf("lat_load%0d", k), load_a[k], 1);
    chk($sformatf("lat_first_bit%0d", k), out_a[k], msbf(k) ? w[W-1] : w[0]);
    chk($sformatf("lat_ready%0d", k), ready_a[k], 0);
    if (!keep) begin
      @(negedge clk);
      valid_a[k] = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0 || !ready_a[0] || !ready_a[1]) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", (exp_q0.size() + exp_q1.size()), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin valid_a[k] = 1'b0; din_a[k] = '0; end
    #3;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst_ready%0d", k), ready_a[k], 1);
      chk($sformatf("rst_busy%0d", k), busy_a[k], 0);
      chk($sformatf("rst_load%0d", k), load_a[k], 0);
      chk($sformatf("rst_out%0d", k), out_a[k], 0);
      chk($sformatf("rst_done%0d", k), done_a[k], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed frames: A5 MSB-first, 01/80 LSB-first with gap, back-to-back FF/00, parity patterns
    send(0, 8'hA5, 1'b0);
    send(1, 8'h01, 1'b0);
    send(1, 8'h80, 1'b0);
    send(0, 8'hFF, 1'b1);
    send(0, 8'h00, 1'b0);
    send(0, 8'h07, 1'b0);
    send(0, 8'h03, 1'b0);
    send(1, 8'h07, 1'b0);
    wait_idle();

    // Asynchronous reset in the middle of a frame
    send(0, 8'h3C, 1'b0);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_load", load_a[0], 0);
    chk("abort_out", out_a[0], 0);
    chk("abort_done", done_a[0], 0);
    chk("abort_ready", ready_a[0], 1);
    exp_q0.delete();
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    send(0, 8'h5A, 1'b0);
    wait_idle();

    // Randomized traffic on both instances concurrently
    fork
      begin
        for (int i = 0; i < 25; i++) begin
          bit keep;
          keep = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
          send(0, W'($urandom), keep);
          if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 25; i++) begin
          bit keep;
          keep = (i < 24) ? 1'($urandom_range(0, 1)) : 1'b0;
          send(1, W'($urandom), keep);
          if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
    join
    wait_idle();
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_serial_tx.md
Name: reg_serial_tx

Overview:
- Parallel-to-serial transmitter that drives the serial register interface: a 1-bit data line `OUT` plus a `Load` strobe.
- A receiving shift/load register consumes this stream, sampling `OUT` on every rising `clk` edge where `Load` = 1.
- Accepts a WIDTH-bit word through a valid/ready handshake, emits it one bit per cycle, then signals completion.
- Sits between the counter/control logic and the register chain in the register-counter datapath.

Parameters:
- WIDTH, 8: data word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is transmitted first; 0 = bit 0 is transmitted first.
- GAP_CYCLES, 0: number of idle cycles forced after each frame, with `Load`=0 and `ready`=0; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- valid  input  1  `din` holds a word to send.
- din  input  WIDTH  parallel word.
- ready  output  1  block can accept a word; equals (state == IDLE).
- OUT  output  1  serial data bit, registered.
- Load  output  1  `OUT` is valid this cycle; the receiver samples `OUT` at the next rising edge. Registered.
- done  output  1  single-cycle pulse after the last bit of a frame. Registered.
- busy  output  1  state != IDLE.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is asynchronous, active-low.
- While `rst_n` = 0:
  - state = IDLE, shift register = 0, bit counter = 0, gap counter = 0.
  - `OUT` = 0, `Load` = 0, `done` = 0, `busy` = 0, `ready` = 1.
- States: IDLE, SHIFT, PAR (only with the optional feature), GAP.
- IDLE:
  - A handshake occurs at a rising edge where `valid` = 1 and `ready` = 1.
  - On a handshake: `din` is captured into the shift register, the bit counter is set to WIDTH-1, and the next state is SHIFT.
  - `valid` in any non-IDLE state is ignored; no queuing, no back-pressure error.
- Latency: the first data bit appears on `OUT` with `Load` = 1 in the cycle immediately after the handshake edge.
- SHIFT:
  - One bit per cycle with `Load` = 1, exactly WIDTH consecutive cycles.
  - Order is set by MSB_FIRST; the shift register shifts once per cycle.
  - The bit counter decrements each cycle. When it reaches 0 and the last bit is on `OUT`, the next state is PAR (feature on) or the end-of-frame step.
- End of frame:
  - `Load` drops to 0 in the cycle after the final driven bit.
  - `done` = 1 for exactly that one cycle.
  - `OUT` returns to 0 in the same cycle.
  - Next state is GAP if GAP_CYCLES > 0, otherwise IDLE.
  - With GAP_CYCLES = 0, `ready` = 1 in the `done` cycle, so a new handshake may occur on that edge. The minimum frame-to-frame period is therefore WIDTH+1 cycles (WIDTH+2 with parity).
- GAP: the gap counter counts GAP_CYCLES cycles with `Load` = 0 and `ready` = 0, then the next state is IDLE.
- Reset mid-frame: the frame is aborted immediately. `Load` and `OUT` go to 0 asynchronously, no `done` pulse is produced, and the partial word is discarded.
- Bit counter width is $clog2(WIDTH). No wrap-around is possible because the counter is reloaded only in IDLE.

Optional Feature:
- Macro: REG_SERIAL_TX_PARITY_EN.
- Defined:
  - After the last data bit, state PAR drives one extra cycle with `Load` = 1.
  - `OUT` in PAR = even parity (XOR of all WIDTH captured bits).
  - `done` follows PAR. Frame length is WIDTH+1 `Load` cycles.
- Undefined:
  - PAR state and parity logic are absent; the frame is WIDTH `Load` cycles.
  - Port list is identical in both builds.

Test Plan:
1. Reset, then `din` = 8'hA5 with `valid` pulsed, MSB_FIRST=1 -> `Load` high 8 cycles, `OUT` sequence 1,0,1,0,0,1,0,1; `done` pulses in cycle 9; `ready` low cycles 1-8.
2. MSB_FIRST=0, `din` = 8'h01 -> `OUT` sequence 1,0,0,0,0,0,0,0; the receiver reassembles 8'h01.
3. `valid` held high continuously, words 8'hFF then 8'h00, GAP_CYCLES=0 -> second frame's first bit in the cycle after `done`; 16 `Load` cycles with exactly one idle cycle between frames; a `valid` change mid-frame has no effect.
4. GAP_CYCLES=3, two words -> `Load` = 0 and `ready` = 0 for 3 cycles after `done`, then `ready` = 1.
5. Assert `rst_n` = 0 asynchronously during bit 4 of 8'h3C -> `Load`/`OUT` go 0 without waiting for an edge; no `done`; after release `ready` = 1 and the next frame is clean.
6. With REG_SERIAL_TX_PARITY_EN, `din` = 8'h07 -> 9 `Load` cycles, 9th bit = 1 (odd count of ones). `din` = 8'h03 -> 9th bit = 0.
